// File: rtl/div320_64_seq.sv
// div320_64_seq: sequential unsigned 320/64 divider (restoring shift/subtract).
// Produces a 256-bit quotient and a 64-bit remainder. Valid/ready handshakes
// are used on both the operand side and the result side.
// Build option: define DIV_RADIX4_EN to retire two quotient bits per cycle
// (128 iterations instead of 256). The results are the same in both builds.
module div320_64_seq (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [319:0] P,
    input  logic [63:0]  B,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [255:0] Q,
    output logic [63:0]  R,
    output logic         div_zero,
    output logic         ovf
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state, state_nxt;
    logic [63:0]    r;      // partial remainder, always < b while running
    logic [255:0]   q;      // dividend low half shifting out, quotient shifting in
    logic [63:0]    b;      // captured divisor
    logic [7:0]     cnt;    // iteration counter
    logic [63:0]    r_step;
    logic [255:0]   q_step;
    logic           accept;
    logic           err_zero;
    logic           err_ovf;
    logic           last;

    assign accept   = in_valid && (state == IDLE);
    assign err_zero = (B == 64'd0);
    // The high dividend word must be below B, or the quotient would need more than 256 bits.
    assign err_ovf  = !err_zero && (P[319:256] >= B);

`ifdef DIV_RADIX4_EN
    localparam logic [7:0] LAST_CNT = 8'd127;

    logic [65:0] t4, b1, b2, b3, d1, d2, d3;

    // One radix-4 step: trial subtractions of 3b, 2b and b. r < b means t < 4b, so 66 bits are enough.
    always_comb begin
        t4 = {r, q[255:254]};
        b1 = {2'b00, b};
        b2 = {1'b0, b, 1'b0};
        b3 = b1 + b2;
        d1 = t4 - b1;
        d2 = t4 - b2;
        d3 = t4 - b3;
        if (t4 >= b3) begin
            r_step = d3[63:0];
            q_step = {q[253:0], 2'b11};
        end else if (t4 >= b2) begin
            r_step = d2[63:0];
            q_step = {q[253:0], 2'b10};
        end else if (t4 >= b1) begin
            r_step = d1[63:0];
            q_step = {q[253:0], 2'b01};
        end else begin
            r_step = t4[63:0];
            q_step = {q[253:0], 2'b00};
        end
    end
`else
    localparam logic [7:0] LAST_CNT = 8'd255;

    logic [64:0] t2, d;

    // One radix-2 restoring step. r < b means t < 2b, so 65 bits are enough.
    always_comb begin
        t2 = {r, q[255]};
        d  = t2 - {1'b0, b};
        if (t2 >= {1'b0, b}) begin
            r_step = d[63:0];
            q_step = {q[254:0], 1'b1};
        end else begin
            r_step = t2[63:0];
            q_step = {q[254:0], 1'b0};
        end
    end
`endif

    assign last = (cnt == LAST_CNT);

    // State register. An asynchronous reset aborts any division in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        // NOTE: every output gets a default first, so no path can leave one unassigned and infer a latch.
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = (err_zero || err_ovf) ? DONE : RUN;
            end
            RUN:  if (last) state_nxt = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: load operands, iterate, and hold the results and flags.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the datapath registers are reset as well as the FSM, so that Q and R read 0 directly after reset.
        if (!rst_n) begin
            r        <= '0;
            q        <= '0;
            b        <= '0;
            cnt      <= '0;
            Q        <= '0;
            R        <= '0;
            div_zero <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments; r_step and q_step are read from the pre-edge r and q.
            case (state)
                IDLE: if (accept) begin
                    if (err_zero) begin
                        div_zero <= 1'b1;
                        Q        <= '0;
                        R        <= '0;
                    end else if (err_ovf) begin
                        ovf      <= 1'b1;
                        Q        <= '0;
                        R        <= '0;
                    end else begin
                        r   <= P[319:256];
                        q   <= P[255:0];
                        b   <= B;
                        cnt <= '0;
                    end
                end
                RUN: begin
                    r   <= r_step;
                    q   <= q_step;
                    cnt <= cnt + 8'd1;
                    if (last) begin
                        Q <= q_step;
                        R <= r_step;
                    end
                end
                DONE: if (out_ready) begin
                    div_zero <= 1'b0;
                    ovf      <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
